// File: rtl/reset_seq_pkg.sv
// Shared types and constants for the reset sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package reset_seq_pkg;

    typedef enum logic [2:0] {
        ST_HOLD,
        ST_ADC_UP,
        ST_CORE_UP,
        ST_RUN,
        ST_DONE,
        ST_FAIL
    } seq_state_t;

    typedef logic [1:0] fail_reason_t;

    localparam fail_reason_t FR_NONE     = 2'd0;
    localparam fail_reason_t FR_TIMEOUT  = 2'd1;
    localparam fail_reason_t FR_EXTERNAL = 2'd2;

    // A phase of N cycles ends when the delay counter reads N-1.
    function automatic logic [15:0] phase_tc(input int unsigned cycles);
        return 16'(cycles - 1);
    endfunction

endpackage

// File: rtl/reset_sequencer_if.sv
// Control/status bundle between the reset sequencer and its environment.
// Latency: n/a (wires only).
// Backpressure: none; slave = sequencer side, master = controlling side.
// Ports: restart/success/fail/max_cycles into the sequencer; four domain
// resets, running/done/failed flags, fail reason and RUN cycle count out.
interface reset_sequencer_if;
    import reset_seq_pkg::*;

    logic         io_restart;
    logic         io_success;
    logic         io_fail;
    logic [63:0]  io_max_cycles;
    logic         io_adc_reset;
    logic         io_core_reset;
    logic         io_ua_reset;
    logic         io_dsp_reset;
    logic         io_running;
    logic         io_done;
    logic         io_failed;
    fail_reason_t io_fail_reason;
    logic [63:0]  io_cycle_count;

    modport slave (
        input  io_restart, io_success, io_fail, io_max_cycles,
        output io_adc_reset, io_core_reset, io_ua_reset, io_dsp_reset,
        output io_running, io_done, io_failed, io_fail_reason, io_cycle_count
    );

    modport master (
        output io_restart, io_success, io_fail, io_max_cycles,
        input  io_adc_reset, io_core_reset, io_ua_reset, io_dsp_reset,
        input  io_running, io_done, io_failed, io_fail_reason, io_cycle_count
    );

endinterface

// File: rtl/delay_counter.sv
// 16-bit phase delay counter with synchronous clear and terminal-count compare.
// Latency: tc is combinational from the registered count (same cycle).
// Backpressure: none; counts every cycle unless clr is high.
// Ports: clock, reset (async, active-high), clr, tc_val in; tc out.
module delay_counter (
    input  logic        clock,
    input  logic        reset,
    input  logic        clr,
    input  logic [15:0] tc_val,
    output logic        tc
);

    logic [15:0] cnt_q;
    logic [15:0] cnt_d;

    always_comb begin
        cnt_d = clr ? 16'd0 : cnt_q + 16'd1;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_q <= 16'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc = (cnt_q == tc_val);

endmodule

// File: rtl/reset_sequencer.sv
// Staged reset release (adc -> core/ua -> dsp) then RUN supervision with timeout.
// Latency: every output is a flop; state and outputs change on the same edge.
// Backpressure: none; restart pulse wins over all other inputs.
// Ports: clock, reset (async, active-high), io (reset_sequencer_if.slave).
module reset_sequencer
    import reset_seq_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES = 16,
    parameter int unsigned CORE_DELAY  = 32,
    parameter int unsigned DSP_DELAY   = 8
) (
    input  logic              clock,
    input  logic              reset,
    reset_sequencer_if.slave  io
);

    localparam logic [15:0] HOLD_TC = phase_tc(HOLD_CYCLES);
    localparam logic [15:0] CORE_TC = phase_tc(CORE_DELAY);
    localparam logic [15:0] DSP_TC  = phase_tc(DSP_DELAY);

    seq_state_t   state_q, state_d;
    logic         adc_reset_q, adc_reset_d;
    logic         core_reset_q, core_reset_d;
    logic         dsp_reset_q, dsp_reset_d;
    logic         running_q, running_d;
    logic         done_q, done_d;
    logic         failed_q, failed_d;
    fail_reason_t fail_reason_q, fail_reason_d;
    logic [63:0]  cycle_count_q, cycle_count_d;

    logic         counting;
    logic [15:0]  dc_tc_val;
    logic         dc_tc;
    logic         dc_clr;
    logic         phase_end;

    // One counter serves all three delay phases; the compare value follows
    // the current phase and the count restarts at every phase boundary.
    always_comb begin
        counting  = 1'b1;
        dc_tc_val = 16'hFFFF;
        case (state_q)
            ST_HOLD:    dc_tc_val = HOLD_TC;
            ST_ADC_UP:  dc_tc_val = CORE_TC;
            ST_CORE_UP: dc_tc_val = DSP_TC;
            default:    counting  = 1'b0;
        endcase
    end

    assign phase_end = counting & dc_tc;
    assign dc_clr    = io.io_restart | phase_end | ~counting;

    delay_counter u_delay_counter (
        .clock  (clock),
        .reset  (reset),
        .clr    (dc_clr),
        .tc_val (dc_tc_val),
        .tc     (dc_tc)
    );

    always_comb begin
        state_d       = state_q;
        fail_reason_d = fail_reason_q;
        cycle_count_d = cycle_count_q;

        case (state_q)
            ST_HOLD:    if (phase_end) state_d = ST_ADC_UP;
            ST_ADC_UP:  if (phase_end) state_d = ST_CORE_UP;
            ST_CORE_UP: if (phase_end) state_d = ST_RUN;
            ST_RUN: begin
                // Exit cycles do not count, so a timeout freezes at max.
                if (io.io_fail) begin
                    state_d       = ST_FAIL;
                    fail_reason_d = FR_EXTERNAL;
                end else if ((io.io_max_cycles != 64'd0) &&
                             (cycle_count_q >= io.io_max_cycles)) begin
                    state_d       = ST_FAIL;
                    fail_reason_d = FR_TIMEOUT;
                end else if (io.io_success) begin
                    state_d = ST_DONE;
                end else if (cycle_count_q != '1) begin
                    cycle_count_d = cycle_count_q + 64'd1;
                end
            end
            ST_DONE, ST_FAIL: ;
            default:    state_d = ST_HOLD;
        endcase

        if (io.io_restart) begin
            state_d       = ST_HOLD;
            fail_reason_d = FR_NONE;
            cycle_count_d = 64'd0;
        end

        // Outputs decode the next state so they land on the same edge.
        adc_reset_d  = (state_d == ST_HOLD);
        core_reset_d = (state_d == ST_HOLD) || (state_d == ST_ADC_UP);
        dsp_reset_d  = (state_d == ST_HOLD) || (state_d == ST_ADC_UP) ||
                       (state_d == ST_CORE_UP);
        running_d    = (state_d == ST_RUN);
        done_d       = (state_d == ST_DONE);
        failed_d     = (state_d == ST_FAIL);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= ST_HOLD;
            adc_reset_q   <= 1'b1;
            core_reset_q  <= 1'b1;
            dsp_reset_q   <= 1'b1;
            running_q     <= 1'b0;
            done_q        <= 1'b0;
            failed_q      <= 1'b0;
            fail_reason_q <= FR_NONE;
            cycle_count_q <= 64'd0;
        end else begin
            state_q       <= state_d;
            adc_reset_q   <= adc_reset_d;
            core_reset_q  <= core_reset_d;
            dsp_reset_q   <= dsp_reset_d;
            running_q     <= running_d;
            done_q        <= done_d;
            failed_q      <= failed_d;
            fail_reason_q <= fail_reason_d;
            cycle_count_q <= cycle_count_d;
        end
    end

    // core and ua domains share one release point, hence one flop.
    assign io.io_adc_reset   = adc_reset_q;
    assign io.io_core_reset  = core_reset_q;
    assign io.io_ua_reset    = core_reset_q;
    assign io.io_dsp_reset   = dsp_reset_q;
    assign io.io_running     = running_q;
    assign io.io_done        = done_q;
    assign io.io_failed      = failed_q;
    assign io.io_fail_reason = fail_reason_q;
    assign io.io_cycle_count = cycle_count_q;

endmodule
